// File: rtl/lsu_dmem_ctrl.sv
// Load/store controller in front of a single-port synchronous data_ram.
// Optional misalignment exceptions are enabled by defining LSU_ALE_CHECK_EN.
module lsu_dmem_ctrl #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [3:0]            req_op,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_ale,
   output logic                  ram_en,
   output logic [3:0]            ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LWAIT = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;

   localparam logic [3:0] OP_LD_B  = 4'd0;
   localparam logic [3:0] OP_LD_H  = 4'd1;
   localparam logic [3:0] OP_LD_W  = 4'd2;
   localparam logic [3:0] OP_LD_BU = 4'd3;
   localparam logic [3:0] OP_LD_HU = 4'd4;
   localparam logic [3:0] OP_ST_B  = 4'd8;
   localparam logic [3:0] OP_ST_H  = 4'd9;
   localparam logic [3:0] OP_ST_W  = 4'd10;

   logic [1:0] state;
   logic       is_b, is_h, is_w, is_load, is_store, legal, mis;
   logic       accept, go;
   logic [1:0] eff_off;
   logic [3:0] we_mask;
   logic [3:0] op_p0;
   logic [1:0] off_p0;
   logic       unused_addr_hi;

   // Lane select plus sign/zero extension of the returned RAM word.
   function automatic logic [31:0] load_extend(input logic [3:0]  op,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] bs;
      logic signed [31:0] hs;
      b  = word[{off, 3'b000} +: 8];
      h  = word[{off[1], 4'b0000} +: 16];
      bs = b;
      hs = h;
      case (op)
         OP_LD_B:  return bs;
         OP_LD_H:  return hs;
         OP_LD_BU: return {24'b0, b};
         OP_LD_HU: return {16'b0, h};
         default:  return word;
      endcase
   endfunction

   always_comb begin
      is_b     = 1'b0;
      is_h     = 1'b0;
      is_w     = 1'b0;
      is_load  = 1'b0;
      is_store = 1'b0;
      case (req_op)
         OP_LD_B, OP_LD_BU: begin is_load  = 1'b1; is_b = 1'b1; end
         OP_LD_H, OP_LD_HU: begin is_load  = 1'b1; is_h = 1'b1; end
         OP_LD_W:           begin is_load  = 1'b1; is_w = 1'b1; end
         OP_ST_B:           begin is_store = 1'b1; is_b = 1'b1; end
         OP_ST_H:           begin is_store = 1'b1; is_h = 1'b1; end
         OP_ST_W:           begin is_store = 1'b1; is_w = 1'b1; end
         default:           ;
      endcase
      legal = is_load | is_store;
   end

`ifdef LSU_ALE_CHECK_EN
   assign mis = legal && ((is_h && req_addr[0]) || (is_w && (req_addr[1:0] != 2'b00)));
`else
   assign mis = 1'b0;
`endif

   // Aligned-down lane offset; identical to addr[1:0] for any op that is allowed to access RAM
   // when ALE checking is on, and the wrap-down behaviour when it is off.
   assign eff_off = is_w ? 2'b00 : (is_h ? {req_addr[1], 1'b0} : req_addr[1:0]);

   assign accept    = req_valid && (state == IDLE);
   assign go        = accept && legal && !mis;
   assign req_ready = (state == IDLE);
   assign resp_valid = (state == RESP);

   always_comb begin
      we_mask = 4'b1111;
      if (is_b)      we_mask = 4'b0001 << eff_off;
      else if (is_h) we_mask = 4'b0011 << eff_off;
   end

   assign ram_en    = go;
   assign ram_we    = (go && is_store) ? we_mask : 4'b0000;
   assign ram_addr  = req_addr[ADDR_WIDTH+1:2];
   assign ram_wdata = is_b ? {4{req_wdata[7:0]}} :
                      is_h ? {2{req_wdata[15:0]}} : req_wdata;

   assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

   // Control state and the held response registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         resp_rdata <= '0;
         resp_ale   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (go && is_load) begin
                     state <= LWAIT;
                  end else begin
                     state      <= RESP;
                     resp_rdata <= '0;
                     resp_ale   <= mis;
                  end
               end
            end
            LWAIT: begin
               resp_rdata <= load_extend(op_p0, off_p0, ram_rdata);
               resp_ale   <= 1'b0;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stage p0: load op and lane offset captured on the accept edge.
   always_ff @(posedge clk) begin
      if (go && is_load) begin
         op_p0  <= req_op;
         off_p0 <= eff_off;
      end
   end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Directed, scoreboard-based bench for lsu_dmem_ctrl with a behavioural byte-enable RAM.
module tb_lsu_dmem_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = 4'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_ale;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [15:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   int checks = 0;
   int failures = 0;
   int acc = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        ale;
      int          lat;
   } exp_t;
   exp_t sb[$];

   logic [31:0] mem [0:65535];

   lsu_dmem_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_ale(resp_ale),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_en) begin
         acc <= acc + 1;
         ram_rdata <= mem[ram_addr];
         for (int i = 0; i < 4; i++)
            if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One op: drive, check RAM port, wait for response, optionally hold it, then release.
   task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic en_e, input logic [3:0] we_e,
                        input logic [31:0] wd_e, input int lat_e, input logic [31:0] rd_e,
                        input logic ale_e, input int hold);
      exp_t e;
      int   lat;
      int   acc0;
      logic [31:0] rd_obs;
      req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      #1;
      chk({tag, ".ram_en"}, 32'(ram_en), 32'(en_e));
      chk({tag, ".ram_we"}, 32'(ram_we), 32'(we_e));
      if (en_e) chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(addr[17:2]));
      if (we_e != 4'b0000) chk({tag, ".ram_wdata"}, ram_wdata, wd_e);
      e.rdata = rd_e; e.ale = ale_e; e.lat = lat_e;
      sb.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      e = sb.pop_front();
      chk({tag, ".latency"}, 32'(lat), 32'(e.lat));
      chk({tag, ".rdata"}, resp_rdata, e.rdata);
      chk({tag, ".ale"}, 32'(resp_ale), 32'(e.ale));
      rd_obs = resp_rdata;
      acc0 = acc;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
         chk({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
         chk({tag, ".hold_rdata"}, resp_rdata, rd_obs);
         chk({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
         if (i == 2) begin
            req_op = 4'd10; req_addr = 32'h100; req_wdata = 32'h0BADF00D; req_valid = 1'b1;
            #1;
            chk({tag, ".hold_ram_en"}, 32'(ram_en), 32'd0);
         end
      end
      if (hold > 0) begin
         req_valid = 1'b0;
         chk({tag, ".hold_no_access"}, 32'(acc), 32'(acc0));
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk({tag, ".released"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      int acc0;
      #1;
      chk("rst.req_ready", 32'(req_ready), 32'd1);
      chk("rst.resp_valid", 32'(resp_valid), 32'd0);
      chk("rst.resp_rdata", resp_rdata, 32'd0);
      chk("rst.resp_ale", 32'(resp_ale), 32'd0);
      chk("rst.ram_en", 32'(ram_en), 32'd0);
      chk("rst.ram_we", 32'(ram_we), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      do_op("st_w",  4'd10, 32'h100, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF, 1, 32'h0, 1'b0, 0);
      do_op("ld_w",  4'd2,  32'h100, 32'h0,        1'b1, 4'b0000, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0);
      do_op("st_b",  4'd8,  32'h103, 32'h00000080, 1'b1, 4'b1000, 32'h80808080, 1, 32'h0, 1'b0, 0);
      do_op("ld_b",  4'd0,  32'h103, 32'h0,        1'b1, 4'b0000, 32'h0, 2, 32'hFFFFFF80, 1'b0, 0);
      do_op("ld_bu", 4'd3,  32'h103, 32'h0,        1'b1, 4'b0000, 32'h0, 2, 32'h00000080, 1'b0, 0);
      do_op("ld_w2", 4'd2,  32'h100, 32'h0,        1'b1, 4'b0000, 32'h0, 2, 32'h80ADBEEF, 1'b0, 0);
      do_op("st_h",  4'd9,  32'h202, 32'h1234ABCD, 1'b1, 4'b1100, 32'hABCDABCD, 1, 32'h0, 1'b0, 0);
      do_op("ld_h",  4'd1,  32'h202, 32'h0,        1'b1, 4'b0000, 32'h0, 2, 32'hFFFFABCD, 1'b0, 0);
      do_op("ld_hu", 4'd4,  32'h202, 32'h0,        1'b1, 4'b0000, 32'h0, 2, 32'h0000ABCD, 1'b0, 0);
      do_op("ld_b0", 4'd0,  32'h101, 32'h0,        1'b1, 4'b0000, 32'h0, 2, 32'hFFFFFFBE, 1'b0, 0);
      do_op("wrap",  4'd2,  32'hFFFC0100, 32'h0,   1'b1, 4'b0000, 32'h0, 2, 32'h80ADBEEF, 1'b0, 0);
`ifdef LSU_ALE_CHECK_EN
      acc0 = acc;
      do_op("ale_w", 4'd2,  32'h101, 32'h0,        1'b0, 4'b0000, 32'h0, 1, 32'h0, 1'b1, 0);
      do_op("ale_h", 4'd9,  32'h203, 32'h5555,     1'b0, 4'b0000, 32'h0, 1, 32'h0, 1'b1, 0);
      chk("ale.no_access", 32'(acc), 32'(acc0));
`else
      do_op("mis_w", 4'd2,  32'h101, 32'h0,        1'b1, 4'b0000, 32'h0, 2, 32'h80ADBEEF, 1'b0, 0);
      do_op("mis_h", 4'd4,  32'h203, 32'h0,        1'b1, 4'b0000, 32'h0, 2, 32'h0000ABCD, 1'b0, 0);
`endif
      acc0 = acc;
      do_op("illegal", 4'd5, 32'h100, 32'h0,       1'b0, 4'b0000, 32'h0, 1, 32'h0, 1'b0, 0);
      chk("illegal.no_access", 32'(acc), 32'(acc0));
      do_op("hold",  4'd4,  32'h202, 32'h0,        1'b1, 4'b0000, 32'h0, 2, 32'h0000ABCD, 1'b0, 5);
      do_op("hold_after", 4'd2, 32'h100, 32'h0,    1'b1, 4'b0000, 32'h0, 2, 32'h80ADBEEF, 1'b0, 0);

      // Reset while a load sits in LWAIT.
      req_op = 4'd2; req_addr = 32'h100; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_mid.req_ready", 32'(req_ready), 32'd1);
      chk("rst_mid.resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mid.resp_rdata", resp_rdata, 32'd0);
      chk("rst_mid.ram_we", 32'(ram_we), 32'd0);
      acc0 = acc;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst_mid.no_resp", 32'(resp_valid), 32'd0);
      end
      chk("rst_mid.no_access", 32'(acc), 32'(acc0));
      chk("rst_mid.sb_empty", 32'(sb.size()), 32'd0);
      do_op("post_rst", 4'd2, 32'h100, 32'h0,      1'b1, 4'b0000, 32'h0, 2, 32'h80ADBEEF, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
